// File: rtl/sram_port_sched_pkg.sv
// Shared types for the SRAM port scheduler: FSM state encoding, owner codes and grant bit positions.
package sram_port_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_B_CMD = 3'd1,
        ST_B_CAP = 3'd2,
        ST_W_LO  = 3'd3,
        ST_W_HI  = 3'd4,
        ST_W_CAP = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OWN_LD = 2'd0,
        OWN_IF = 2'd1,
        OWN_D  = 2'd2
    } owner_t;

    localparam int GNT_LD = 0;
    localparam int GNT_IF = 1;
    localparam int GNT_D  = 2;

endpackage

// File: rtl/sram_port_sched_if.sv
// Requester-side bundle of the SRAM port scheduler: loader, instruction fetch and CPU data ports.
interface sram_port_sched_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_W-1:0]     ld_addr;
    logic [DATA_W-1:0]     ld_wdata;
    logic                  ld_ack;

    logic                  if_req;
    logic [ADDR_W-2:0]     if_pc;
    logic [2*DATA_W-1:0]   if_instr;
    logic                  if_ack;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_ack;

    logic [DATA_W-1:0]     rdata;

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        output if_req, if_pc,
        output d_req, d_we, d_addr, d_wdata,
        input  ld_ack, if_instr, if_ack, d_ack, rdata
    );

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  if_req, if_pc,
        input  d_req, d_we, d_addr, d_wdata,
        output ld_ack, if_instr, if_ack, d_ack, rdata
    );
endinterface

// File: rtl/sram_sched_arb.sv
// Fixed-priority grant for the SRAM scheduler; load mode serves only the loader.
module sram_sched_arb
    import sram_port_sched_pkg::*;
(
    input  logic       load_n,
    input  logic       ld_req,
    input  logic       if_req,
    input  logic       d_req,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (!load_n) begin
            grant[GNT_LD] = ld_req;
        end else if (d_req) begin
            grant[GNT_D] = 1'b1;
        end else if (if_req) begin
            grant[GNT_IF] = 1'b1;
        end else begin
            grant[GNT_LD] = ld_req;
        end
    end

endmodule

// File: rtl/sram_port_sched.sv
// Single-port SRAM scheduler: byte accesses for loader/CPU data, two-byte instruction fetch.
// Optional CPU write protection above WPROT_BASE is enabled by defining SRAM_SCHED_WPROT_EN.
module sram_port_sched
    import sram_port_sched_pkg::*;
#(
    parameter int              ADDR_W     = 9,
    parameter int              DATA_W     = 8,
    parameter logic [ADDR_W-1:0] WPROT_BASE = 9'h020
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_n,
    sram_port_sched_if.slave  bus,
    output logic              sram_cen_n,
    output logic              sram_wen_n,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic              wp_err
);

`ifdef SRAM_SCHED_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    logic [2:0]          grant;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                gnt_we;
    logic [DATA_W-1:0]   gnt_wdata;
    owner_t              gnt_owner;
    logic                prot_drop;

    state_t              state_reg;
    owner_t              owner_reg;
    logic                we_reg;
    logic [ADDR_W-2:0]   pc_reg;
    logic [DATA_W-1:0]   lo_reg;
    logic                cen_n_reg, wen_n_reg;
    logic [ADDR_W-1:0]   sram_a_reg;
    logic [DATA_W-1:0]   sram_d_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [2*DATA_W-1:0] if_instr_reg;
    logic                ld_ack_reg, if_ack_reg, d_ack_reg, wp_err_reg;

    sram_sched_arb u_arb (
        .load_n (load_n),
        .ld_req (bus.ld_req),
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .grant  (grant)
    );

    always_comb begin
        gnt_addr  = bus.ld_addr;
        gnt_we    = bus.ld_we;
        gnt_wdata = bus.ld_wdata;
        gnt_owner = OWN_LD;
        if (grant[GNT_D]) begin
            gnt_addr  = bus.d_addr;
            gnt_we    = bus.d_we;
            gnt_wdata = bus.d_wdata;
            gnt_owner = OWN_D;
        end else if (grant[GNT_IF]) begin
            gnt_addr  = {bus.if_pc, 1'b0};
            gnt_we    = 1'b0;
            gnt_wdata = '0;
            gnt_owner = OWN_IF;
        end
    end

    assign prot_drop = WPROT_ON && grant[GNT_D] && bus.d_we && (bus.d_addr >= WPROT_BASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_LD;
            we_reg       <= 1'b0;
            pc_reg       <= '0;
            lo_reg       <= '0;
            cen_n_reg    <= 1'b1;
            wen_n_reg    <= 1'b1;
            sram_a_reg   <= '0;
            sram_d_reg   <= '0;
            rdata_reg    <= '0;
            if_instr_reg <= '0;
            ld_ack_reg   <= 1'b0;
            if_ack_reg   <= 1'b0;
            d_ack_reg    <= 1'b0;
            wp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        owner_reg  <= gnt_owner;
                        we_reg     <= gnt_we;
                        pc_reg     <= gnt_addr[ADDR_W-1:1];
                        sram_a_reg <= gnt_addr;
                        sram_d_reg <= gnt_wdata;
                        if (prot_drop) begin
                            d_ack_reg  <= 1'b1;
                            wp_err_reg <= 1'b1;
                            state_reg  <= ST_DONE;
                        end else if (grant[GNT_IF]) begin
                            cen_n_reg <= 1'b0;
                            state_reg <= ST_W_LO;
                        end else begin
                            cen_n_reg <= 1'b0;
                            wen_n_reg <= ~gnt_we;
                            state_reg <= ST_B_CMD;
                        end
                    end
                end
                ST_B_CMD: begin
                    cen_n_reg <= 1'b1;
                    wen_n_reg <= 1'b1;
                    if (we_reg) begin
                        ld_ack_reg <= (owner_reg == OWN_LD);
                        d_ack_reg  <= (owner_reg == OWN_D);
                        state_reg  <= ST_DONE;
                    end else begin
                        state_reg  <= ST_B_CAP;
                    end
                end
                ST_B_CAP: begin
                    rdata_reg  <= sram_q;
                    ld_ack_reg <= (owner_reg == OWN_LD);
                    d_ack_reg  <= (owner_reg == OWN_D);
                    state_reg  <= ST_DONE;
                end
                ST_W_LO: begin
                    sram_a_reg <= {pc_reg, 1'b1};
                    state_reg  <= ST_W_HI;
                end
                ST_W_HI: begin
                    lo_reg    <= sram_q;
                    cen_n_reg <= 1'b1;
                    state_reg <= ST_W_CAP;
                end
                ST_W_CAP: begin
                    if_instr_reg <= {sram_q, lo_reg};
                    if_ack_reg   <= 1'b1;
                    state_reg    <= ST_DONE;
                end
                // The bubble back through IDLE lets a requester drop its held req after the ack.
                ST_DONE: begin
                    ld_ack_reg <= 1'b0;
                    if_ack_reg <= 1'b0;
                    d_ack_reg  <= 1'b0;
                    wp_err_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign sram_cen_n   = cen_n_reg;
    assign sram_wen_n   = wen_n_reg;
    assign sram_a       = sram_a_reg;
    assign sram_d       = sram_d_reg;
    assign wp_err       = wp_err_reg;
    assign bus.rdata    = rdata_reg;
    assign bus.if_instr = if_instr_reg;
    assign bus.ld_ack   = ld_ack_reg;
    assign bus.if_ack   = if_ack_reg;
    assign bus.d_ack    = d_ack_reg;

endmodule
